// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO, oversampled bit timing, CTS gating and break; write-to-line 2 cycles when idle.
// Backpressure: fifo_full flags a full FIFO, writes while full are dropped and flagged by a one-cycle ovf.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_pulse,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          fifo_clr,
  input  logic [1:0]                    wls,
  input  logic                          stb,
  input  logic                          pen,
  input  logic                          eps,
  input  logic                          sticky_parity,
  input  logic                          set_break,
  input  logic                          cts_n,
  output logic                          tx,
  output logic                          busy,
  output logic                          thre,
  output logic                          temt,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(2 * OVERSAMPLE + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [TW-1:0] T_BIT    = TW'(OVERSAMPLE);
  localparam logic [TW-1:0] T_1P5    = TW'((3 * OVERSAMPLE) / 2);
  localparam logic [TW-1:0] T_2      = TW'(2 * OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          push, pop, full, empty;

  logic [TW-1:0] tick_cnt, tick_lim;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [1:0]    c_wls;
  logic          c_stb, c_pen, par_bit;
  logic          tick_end, last_bit;
  logic [7:0]    head, word;
  logic          par_new;

  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);
  assign push  = wr_en & ~full & ~fifo_clr;
  assign pop   = (state == IDLE) & ~empty & ~cts_n;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Clear wins over a same-cycle write; that write is neither stored nor flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= wr_en & full & ~fifo_clr;
      if (fifo_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (!push && pop) level <= level - LW'(1);
      end
    end
  end

  // Parity is resolved at load from the masked word so later config changes cannot touch it.
  assign head    = mem[rd_ptr];
  assign word    = head & (8'hFF >> (2'd3 - wls));
  assign par_new = sticky_parity ? ~eps : (eps ? ^word : ~^word);

  always_comb begin
    tick_lim = T_BIT;
    if (state == STOP && c_stb) tick_lim = (c_wls == 2'b00) ? T_1P5 : T_2;
  end

  assign tick_end = baud_pulse & (tick_cnt == tick_lim - TW'(1));
  assign last_bit = (bit_cnt == {1'b0, c_wls} + 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      c_wls    <= '0;
      c_stb    <= 1'b0;
      c_pen    <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      if (state != IDLE && baud_pulse) tick_cnt <= tick_end ? '0 : tick_cnt + TW'(1);
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            shreg    <= head;
            c_wls    <= wls;
            c_stb    <= stb;
            c_pen    <= pen;
            par_bit  <= par_new;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
          end else begin
            tx <= ~set_break;
          end
        end
        START: begin
          if (tick_end) begin
            state <= DATA;
            tx    <= ~set_break & shreg[0];
          end else begin
            tx <= 1'b0;
          end
        end
        DATA: begin
          if (tick_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              state <= c_pen ? PARITY : STOP;
              tx    <= ~set_break & (c_pen ? par_bit : 1'b1);
            end else begin
              tx <= ~set_break & shreg[1];
            end
          end else begin
            tx <= ~set_break & shreg[0];
          end
        end
        PARITY: begin
          if (tick_end) begin
            state <= STOP;
            tx    <= ~set_break;
          end else begin
            tx <= ~set_break & par_bit;
          end
        end
        STOP: begin
          if (tick_end) state <= IDLE;
          tx <= ~set_break;
        end
        default: begin
          state <= IDLE;
          tx    <= ~set_break;
        end
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign thre       = empty;
  assign temt       = empty & ~busy;
  assign fifo_full  = full;
  assign fifo_level = level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-tick line trace compared against a frame scoreboard.
module tb_uart_tx_fifo;
  localparam int OS    = 3;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_clr;
  logic [1:0] wls;
  logic       stb, pen, eps, sticky_parity, set_break, cts_n;
  logic       tx, busy, thre, temt, fifo_full, ovf;
  logic [4:0] fifo_level;

  typedef struct {
    logic [63:0] bits;
    int          len;
  } frame_t;

  frame_t      q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] cur_bits = '0;
  logic [63:0] cur_care = '0;
  int          cur_len = 0;
  logic        brk_prev = 1'b0;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_clr(fifo_clr), .wls(wls), .stb(stb), .pen(pen), .eps(eps),
    .sticky_parity(sticky_parity), .set_break(set_break), .cts_n(cts_n),
    .tx(tx), .busy(busy), .thre(thre), .temt(temt), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line, one entry per counted baud tick, for a frame with the given settings.
  function automatic frame_t exp_frame(input logic [7:0] d, input logic [1:0] w, input logic s,
                                       input logic p, input logic e, input logic sp);
    frame_t     f;
    int         nb, st;
    logic [7:0] m;
    logic       par;
    nb  = 5 + int'(w);
    m   = d & (8'hFF >> (3 - int'(w)));
    par = sp ? ~e : (e ? ^m : ~^m);
    st  = !s ? OS : ((w == 2'b00) ? (3 * OS) / 2 : 2 * OS);
    f.bits = '0;
    f.len  = 0;
    for (int k = 0; k < OS; k++) begin f.bits[f.len] = 1'b0; f.len++; end
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < OS; k++) begin f.bits[f.len] = d[b]; f.len++; end
    if (p) for (int k = 0; k < OS; k++) begin f.bits[f.len] = par; f.len++; end
    for (int k = 0; k < st; k++) begin f.bits[f.len] = 1'b1; f.len++; end
    return f;
  endfunction

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (!(q.size() == 0 && cur_len == 0 && temt) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("drain_in_time", 64'(c < maxc), 64'd1);
  endtask

  initial begin
    baud_pulse = 1'b0;
    forever begin
      @(negedge clk);
      baud_pulse = ~baud_pulse;
    end
  end

  // Line monitor: records tx on every counted tick of a frame, compares when busy drops.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        cur_len  = 0;
        cur_bits = '0;
        cur_care = '0;
      end else if (busy) begin
        if (baud_pulse && cur_len < 64) begin
          cur_bits[cur_len] = tx;
          cur_care[cur_len] = ~brk_prev;
          cur_len++;
        end
      end else if (cur_len > 0) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", 64'(cur_len), 64'd0);
        end else begin
          f = q.pop_front();
          chk("frame_len", 64'(cur_len), 64'(f.len));
          chk("frame_bits", cur_bits & cur_care, f.bits & cur_care);
        end
        cur_len  = 0;
        cur_bits = '0;
        cur_care = '0;
      end
      brk_prev = set_break;
    end
  end

  initial begin
    int ovf_cnt, ovf_at;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0;
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
    set_break = 1'b0; cts_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_thre", 64'(thre), 64'd1);
    chk("rst_temt", 64'(temt), 64'd1);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8E2, 0x13, with write-to-line latency
    wls = 2'b11; pen = 1'b1; eps = 1'b1; stb = 1'b1;
    wr_en = 1'b1; wr_data = 8'h13;
    q.push_back(exp_frame(8'h13, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_level1", 64'(fifo_level), 64'd1);
    chk("lat_thre", 64'(thre), 64'd0);
    chk("lat_idle_tx", 64'(tx), 64'd1);
    @(negedge clk);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_start_tx", 64'(tx), 64'd0);
    chk("lat_popped", 64'(fifo_level), 64'd0);
    wait_done(400);
    chk("8e2_temt", 64'(temt), 64'd1);

    // 5-bit, 1.5 stop, odd parity
    wls = 2'b00; stb = 1'b1; pen = 1'b1; eps = 1'b0;
    q.push_back(exp_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
    write_byte(8'hFF);
    wait_done(400);

    // push+pop in one cycle, then config change mid-frame only affects the next frame
    wls = 2'b10; stb = 1'b0; pen = 1'b1; eps = 1'b0;
    q.push_back(exp_frame(8'h41, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
    q.push_back(exp_frame(8'hC5, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h41;
    @(negedge clk); wr_data = 8'hC5;
    chk("pp_level_a", 64'(fifo_level), 64'd1);
    @(negedge clk); wr_en = 1'b0;
    chk("pp_level_b", 64'(fifo_level), 64'd1);
    chk("pp_busy", 64'(busy), 64'd1);
    wls = 2'b01; stb = 1'b1; pen = 1'b0;
    wait_done(600);

    // overflow with CTS held off
    wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0;
    cts_n = 1'b1;
    ovf_cnt = 0; ovf_at = -1;
    for (int k = 0; k <= DEPTH + 1; k++) begin
      @(negedge clk);
      if (k > 0 && ovf) begin ovf_cnt++; ovf_at = k - 1; end
      if (k <= DEPTH) begin
        wr_en   = 1'b1;
        wr_data = 8'(k * 37 + 5);
        if (k < DEPTH) q.push_back(exp_frame(8'(k * 37 + 5), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
        wr_en = 1'b0;
      end
    end
    chk("ovf_level", 64'(fifo_level), 64'(DEPTH));
    chk("ovf_full", 64'(fifo_full), 64'd1);
    chk("ovf_count", 64'(ovf_cnt), 64'd1);
    chk("ovf_on_17th", 64'(ovf_at), 64'(DEPTH));
    chk("cts_tx_high", 64'(tx), 64'd1);
    chk("cts_not_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("ovf_one_cycle", 64'(ovf), 64'd0);
    cts_n = 1'b0;
    wait_done(3000);

    // sticky parity with a break window mid-DATA
    wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b1; stb = 1'b0;
    q.push_back(exp_frame(8'h7F, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1));
    write_byte(8'h7F);
    repeat (10) @(negedge clk);
    set_break = 1'b1;
    @(negedge clk);
    chk("break_tx_low", 64'(tx), 64'd0);
    repeat (3) @(negedge clk);
    set_break = 1'b0;
    wait_done(400);
    sticky_parity = 1'b0;

    // clear with a same-cycle write while a frame is active and 3 bytes are queued
    pen = 1'b0;
    q.push_back(exp_frame(8'hA1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hA1;
    @(negedge clk); wr_data = 8'hB2;
    @(negedge clk); wr_data = 8'hC3;
    @(negedge clk); wr_data = 8'hD4;
    @(negedge clk); wr_en = 1'b0;
    chk("clr_pre_level", 64'(fifo_level), 64'd3);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hEE; fifo_clr = 1'b1;
    @(negedge clk); wr_en = 1'b0; fifo_clr = 1'b0;
    chk("clr_level", 64'(fifo_level), 64'd0);
    chk("clr_no_ovf", 64'(ovf), 64'd0);
    chk("clr_frame_alive", 64'(busy), 64'd1);
    wait_done(400);
    repeat (40) @(negedge clk);
    chk("clr_no_more", 64'(busy), 64'd0);

    // asynchronous reset mid-frame with bytes queued
    q.push_back(exp_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); wr_data = 8'h66;
    @(negedge clk); wr_data = 8'h77;
    @(negedge clk); wr_en = 1'b0;
    repeat (12) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_tx", 64'(tx), 64'd1);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_temt", 64'(temt), 64'd1);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("arst_quiet_busy", 64'(busy), 64'd0);
    chk("arst_quiet_tx", 64'(tx), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, oversampled bit timing and CTS flow control. It is the successor to the single-holding-register `tx` block. The host writes bytes into the FIFO. The block serialises them as 16550-compatible frames, taking its bit timing from the shared `baud_pulse` strobe. It sits between the register-file write path and the `tx` pin.

## Interface
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `OVERSAMPLE`, default 16: `baud_pulse` ticks per bit; ≥2.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `baud_pulse` in 1: one-cycle oversample tick.
- `wr_en` in 1: push `wr_data` into the FIFO.
- `wr_data` in 8: byte to transmit.
- `fifo_clr` in 1: synchronous FIFO flush.
- `wls` in 2: word length select; 00=5, 01=6, 10=7, 11=8 data bits.
- `stb` in 1: stop-bit select; 0 = 1 stop bit, 1 = 1.5 stop bits (5-bit words) or 2 stop bits (6–8-bit words).
- `pen` in 1: parity enable.
- `eps` in 1: even parity select.
- `sticky_parity` in 1: stick parity.
- `set_break` in 1: force line low.
- `cts_n` in 1: clear-to-send, active-low.
- `tx` out 1: serial line, registered.
- `busy` out 1: a frame is in progress.
- `thre` out 1: FIFO empty.
- `temt` out 1: FIFO empty and shifter idle.
- `fifo_full` out 1: FIFO full.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- `ovf` out 1: one-cycle pulse when a write is dropped.

## Operation
- **Reset** (immediate, asynchronous):
  - `tx`=1, `busy`=0, `thre`=1, `temt`=1, `fifo_full`=0, `fifo_level`=0, `ovf`=0.
  - FSM=IDLE; all counters 0.
  - Reset asserted mid-frame aborts the frame and discards FIFO contents.
- **FIFO write:**
  - `wr_en` while not full: push; `fifo_level` increments.
  - `wr_en` while full: drop the write and pulse `ovf` next cycle. This applies even if a pop occurs in the same cycle.
  - Simultaneous push and pop: `fifo_level` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FIFO clear:**
  - `fifo_clr` empties the FIFO the next cycle and has priority over a same-cycle write; that write is discarded with no `ovf`.
  - It does not abort the frame in progress.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** if FIFO non-empty and `cts_n`=0, pop the head into the shifter and latch `wls`/`stb`/`pen`/`eps`/`sticky_parity`. Clear the tick counter and go to START.
  - **Config latching:** configuration changes mid-frame do not affect the current frame.
  - **Tick counting:** each state counts `baud_pulse` ticks. A state ends on the clock edge that samples the OVERSAMPLE-th tick.
  - **START:** `tx`=0 for one bit, then DATA.
  - **DATA:** LSB first, 5+`wls` bits. Bits above the word length are ignored, including for parity. Then PARITY if `pen`, else STOP.
  - **PARITY:** the bit value is chosen as follows.
    - `sticky_parity`=1: bit = ~`eps`.
    - Otherwise `eps`=1: bit = XOR of the data bits.
    - Otherwise `eps`=0: bit = XNOR of the data bits.
  - **STOP:** `tx`=1 for the selected stop length.
    - 1 bit = OVERSAMPLE ticks.
    - 1.5 bits = (3·OVERSAMPLE)/2 ticks, truncated.
    - 2 bits = 2·OVERSAMPLE ticks.
  - **Leaving STOP:** return to IDLE. Back-to-back frames therefore have a one-clock IDLE gap with `tx`=1.
- **CTS:** `cts_n` is evaluated only in IDLE. A frame already started always completes.
- **Break:** `set_break`=1 forces `tx`=0 from the next clock, in any state. The FSM keeps running, and the character is lost to the line.
- **Status outputs:**
  - `busy`=1 in every state except IDLE.
  - `thre`=(`fifo_level`==0).
  - `temt`=`thre` & !`busy`.

## Timing
- Write-to-line latency with FSM idle, `cts_n`=0, FIFO empty:
  - cycle N: `wr_en`.
  - N+1: entry visible, `thre` falls.
  - N+1: IDLE sees non-empty and pops.
  - N+2: `tx` falls and `busy` is high.
- Frame length in `baud_pulse` ticks = OVERSAMPLE·(1+data+parity) + stop ticks.
- All status outputs are registered or derived from registered state; there are no combinational paths from inputs to outputs.
- `baud_pulse` may be asserted in the same cycle as a load; that tick is not counted.

## Test plan
- **Reset values:** assert `rst` mid-frame, asynchronously between edges → `tx`=1, `fifo_level`=0, `temt`=1 immediately, with no further frame activity.
- **8E2 frame:** `OVERSAMPLE`=2, `wls`=11, `pen`=1, `eps`=1, `stb`=1, write 0x13 → `tx` bits 0,1,1,0,0,1,0,0,0,1,1,1, each lasting 2 ticks. Then `temt`=1.
- **5-bit, 1.5 stop, odd parity:** `wls`=00, `stb`=1, `pen`=1, `eps`=0, write 0xFF → data 1,1,1,1,1, parity 0, stop high for 24 ticks at `OVERSAMPLE`=16.
- **Overflow:** hold `cts_n`=1 and write 17 bytes → `fifo_level`=16, `fifo_full`=1, a single `ovf` pulse on the 17th write, `tx` stays 1. Release `cts_n` → 16 frames in write order.
- **Break and sticky parity:** `sticky_parity`=1, `eps`=1 → parity bit 0. Assert `set_break` mid-DATA → `tx`=0 next cycle. Deassert it → the line resumes FSM output and the frame ends on schedule.
- **Clear during a frame:** `fifo_clr` asserted together with `wr_en` while 3 bytes are queued and a frame is active → current frame completes, `fifo_level`=0, no `ovf`, no further frames.
